// File: rtl/water_led_pkg.sv
// Shared types and helpers for the water LED chaser.
package water_led_pkg;

    // Pattern modes as seen on the mode input
    typedef enum logic [1:0] {
        MODE_LEFT   = 2'b00,
        MODE_RIGHT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    localparam int DEF_LED_NUM = 4;
    localparam int DEF_CNT_MAX = 24_999_999;
    localparam int MAX_LEDS    = 32;

    // One-hot vector with bit 'pos' set, sized for the largest legal LED bank
    function automatic logic [MAX_LEDS-1:0] onehot(input logic [4:0] pos);
        logic [MAX_LEDS-1:0] v;
        v      = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/water_led_tick.sv
// Step prescaler: counts enabled cycles 0..CNT_MAX and flags the terminal
// count as a single-cycle step pulse.
module water_led_tick
    import water_led_pkg::*;
#(
    parameter int CNT_MAX = DEF_CNT_MAX
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic step_tick
);

    localparam int              CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    // Next count and pre-decoded terminal count for the coming cycle
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
        end
        tc_d = (cnt_d == CNT_TOP);
    end

    // Prescaler state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    // The terminal count comes straight from a flop; en gates it so that a
    // cycle sitting at CNT_MAX with en low never produces a step.
    assign step_tick = tc_q & en;

endmodule

// File: rtl/water_led_ctrl.sv
// LED chaser top: prescaler, pattern state (left/right/ping-pong/blink) and
// registered polarity-adjusted LED drive.
// Optional PWM dimming of lit LEDs is enabled by defining WATER_LED_PWM_EN.
module water_led_ctrl
    import water_led_pkg::*;
#(
    parameter int LED_NUM    = DEF_LED_NUM,
    parameter int CNT_MAX    = DEF_CNT_MAX,
    parameter int ACTIVE_LOW = 1,
    parameter int PWM_BITS   = 4,
    localparam int POS_W     = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
`ifdef WATER_LED_PWM_EN
    input  logic [PWM_BITS-1:0] duty,
`endif
    output logic [LED_NUM-1:0] led_out,
    output logic               step_tick,
    output logic [POS_W-1:0]   pos
);

    localparam logic               POL     = (ACTIVE_LOW != 0);
    localparam logic [POS_W-1:0]   LAST    = POS_W'(LED_NUM - 1);
    localparam logic [LED_NUM-1:0] LED_RST = {LED_NUM{POL}} ^ LED_NUM'(1);

    // Elaboration-time parameter sanity checks
    if (LED_NUM < 1 || LED_NUM > MAX_LEDS) begin : g_bad_led_num
        $error("water_led_ctrl: LED_NUM out of range 1..32");
    end
    if (CNT_MAX < 1) begin : g_bad_cnt_max
        $error("water_led_ctrl: CNT_MAX must be >= 1");
    end
    if (PWM_BITS < 1) begin : g_bad_pwm_bits
        $error("water_led_ctrl: PWM_BITS must be >= 1");
    end

    water_led_tick #(
        .CNT_MAX (CNT_MAX)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .step_tick (step_tick)
    );

    mode_e               mode_q, mode_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic                ph_q, ph_d;
    logic [LED_NUM-1:0]  led_q, led_d;
    logic [MAX_LEDS-1:0] oh;
    logic [LED_NUM-1:0]  pattern;
    logic                pwm_on;

`ifdef WATER_LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] duty_eff;

    // Free-running PWM counter; duty is re-captured at the start of each period
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        duty_eff  = (pwm_cnt_q == '0) ? duty : duty_q;
        duty_d    = duty_eff;
        pwm_on    = (pwm_cnt_q < duty_eff);
    end

    // PWM state, independent of en
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
        end
    end
`else
    assign pwm_on = 1'b1;
`endif

    // Pattern step: the new mode is taken on the step and decides the move
    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        ph_d   = ph_q;
        if (step_tick) begin
            mode_d = mode_e'(mode);
            ph_d   = 1'b0;
            unique case (mode_d)
                MODE_LEFT: begin
                    pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                    dir_d = 1'b0;
                end
                MODE_RIGHT: begin
                    pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
                    dir_d = 1'b1;
                end
                MODE_BOUNCE: begin
                    // A single LED has nowhere to go: hold position and direction
                    if (LED_NUM > 1) begin
                        if (!dir_q) begin
                            if (pos_q == LAST) begin
                                dir_d = 1'b1;
                                pos_d = pos_q - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                end
                MODE_BLINK: begin
                    ph_d = ~ph_q;
                end
            endcase
        end
    end

    // Output drive from the next-state pattern so LEDs follow pos with no extra lag
    always_comb begin
        oh = onehot(5'(pos_d));
        if (mode_d == MODE_BLINK) begin
            pattern = {LED_NUM{ph_d}};
        end else begin
            pattern = oh[LED_NUM-1:0];
        end
        led_d = (pattern & {LED_NUM{pwm_on}}) ^ {LED_NUM{POL}};
    end

    // Pattern and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_LEFT;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            ph_q   <= 1'b0;
            led_q  <= LED_RST;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            ph_q   <= ph_d;
            led_q  <= led_d;
        end
    end

    assign led_out = led_q;
    assign pos     = pos_q;

endmodule
